spatial_delay: RTL and testbench

Multi-channel successor to the single-output delay block: one mono sample stream in, CH speaker feeds out, each delayed by a per-channel sample count derived from source angle `theta` and `distance`. Sits between the sample source (AtoD) and the per-speaker output path, clocked by the 50 MHz system clock and advanced by a 44.1 kHz sample strobe. Adds a shared ring buffer, a per-channel read sequencer, slew-limited delay changes and an overrun flag.

---
 rtl/spatial_delay.sv | 182 ++++++++++++++++++
 tb/tb_spatial_delay.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spatial_delay.sv
`default_nettype none
// ============================================================================
// Module      : spatial_delay
// Description : Mono sample stream to CH speaker feeds, each delayed by an
//               angle/distance-derived, slew-limited sample count.
// Revision    : 1.0 - initial release
// ============================================================================
module spatial_delay #(
    parameter int W         = 16,
    parameter int ADDR_W    = 9,
    parameter int CH        = 4,
    parameter int ITD_SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sample_en,
    input  logic [7:0]      theta,
    input  logic [7:0]      distance,
    input  logic [W-1:0]    signal_in,
    output logic [CH*W-1:0] signal_out,
    output logic            out_valid,
    output logic            busy,
    output logic            overrun
);

    localparam int c_DEPTH = 1 << ADDR_W;
    localparam int c_IDX_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int c_SUM_W = (ADDR_W + 1 > 10) ? ADDR_W + 1 : 10;
    localparam int c_STEP  = 256 / CH;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_WRITE = 2'd1;
    localparam logic [1:0] c_S_READ  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [W-1:0]        r_sample;
    logic [7:0]          r_theta;
    logic [7:0]          r_dist;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_last_wr;
    logic [ADDR_W:0]     r_fill;
    logic [ADDR_W-1:0]   r_cur [CH];
    logic [ADDR_W-1:0]   w_target [CH];
    logic [ADDR_W-1:0]   w_cur_nxt [CH];
    logic [c_IDX_W-1:0]  r_rd_idx;
    logic [c_IDX_W-1:0]  r_cap_idx;
    logic                r_cap_vld;
    logic                r_cap_zero;
    logic [W-1:0]        r_rd_data;
    logic [W-1:0]        r_shadow [CH];
    logic [CH*W-1:0]     w_cap_flat;
    logic [ADDR_W-1:0]   w_rd_cur;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_rd_zero;
    logic [CH*W-1:0]     r_out;
    logic                r_out_valid;
    logic                r_overrun;

    logic [W-1:0]        r_mem [c_DEPTH];

    // Per-channel target delay and one-step slew toward it
    generate
        for (genvar c = 0; c < CH; c++) begin : g_target
            localparam logic [7:0] c_ANG = 8'(c * c_STEP);
            logic [7:0]         w_diff;
            logic [7:0]         w_fold;
            logic [c_SUM_W-1:0] w_sum;

            assign w_diff = r_theta - c_ANG;
            // Angles past half a turn fold back: 256 - diff == two's complement
            assign w_fold = (w_diff > 8'd128) ? (~w_diff + 8'd1) : w_diff;
            assign w_sum  = c_SUM_W'(r_dist) + c_SUM_W'(w_fold >> ITD_SHIFT);
            assign w_target[c] = (w_sum > c_SUM_W'(c_DEPTH - 1)) ?
                                 ADDR_W'(c_DEPTH - 1) : w_sum[ADDR_W-1:0];
            assign w_cur_nxt[c] = (r_cur[c] < w_target[c]) ? r_cur[c] + 1'b1 :
                                  (r_cur[c] > w_target[c]) ? r_cur[c] - 1'b1 :
                                  r_cur[c];
        end
    endgenerate

    assign w_rd_cur  = r_cur[r_rd_idx];
    assign w_rd_addr = r_last_wr - w_rd_cur;
    assign w_rd_zero = ({1'b0, w_rd_cur} >= r_fill);

    // Last channel's read lands in DONE, so merge the in-flight capture here
    generate
        for (genvar c = 0; c < CH; c++) begin : g_cap
            assign w_cap_flat[c*W +: W] =
                (r_cap_vld && (r_cap_idx == c_IDX_W'(c))) ?
                    (r_cap_zero ? '0 : r_rd_data) : r_shadow[c];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (sample_en) w_state_nxt = c_S_WRITE;
            c_S_WRITE: w_state_nxt = c_S_READ;
            c_S_READ:  if (r_rd_idx == c_IDX_W'(CH - 1)) w_state_nxt = c_S_DONE;
            c_S_DONE:  w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_sample    <= '0;
            r_theta     <= '0;
            r_dist      <= '0;
            r_wr_ptr    <= '0;
            r_last_wr   <= '0;
            r_fill      <= '0;
            r_rd_idx    <= '0;
            r_cap_idx   <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_zero  <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                r_cur[i]    <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= 1'b0;
            r_cap_vld   <= (r_state == c_S_READ);

            if (sample_en && (r_state != c_S_IDLE))
                r_overrun <= 1'b1;

            if (r_cap_vld)
                r_shadow[r_cap_idx] <= r_cap_zero ? '0 : r_rd_data;

            case (r_state)
                c_S_IDLE: begin
                    if (sample_en) begin
                        r_sample <= signal_in;
                        r_theta  <= theta;
                        r_dist   <= distance;
                    end
                end
                c_S_WRITE: begin
                    r_last_wr <= r_wr_ptr;
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                    r_rd_idx  <= '0;
                    if (r_fill != (ADDR_W + 1)'(c_DEPTH))
                        r_fill <= r_fill + 1'b1;
                    for (int i = 0; i < CH; i++)
                        r_cur[i] <= w_cur_nxt[i];
                end
                c_S_READ: begin
                    r_cap_idx  <= r_rd_idx;
                    r_cap_zero <= w_rd_zero;
                    r_rd_idx   <= r_rd_idx + 1'b1;
                end
                c_S_DONE: begin
                    r_out       <= w_cap_flat;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Ring buffer storage carries no reset
    always_ff @(posedge clk) begin
        if (r_state == c_S_WRITE)
            r_mem[r_wr_ptr] <= r_sample;
        r_rd_data <= r_mem[w_rd_addr];
    end

    assign signal_out = r_out;
    assign out_valid  = r_out_valid;
    assign busy       = (r_state != c_S_IDLE);
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spatial_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_spatial_delay
// Description : Scoreboard bench; two DUTs (deep and shallow ring) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spatial_delay;

    localparam int W    = 16;
    localparam int CH   = 4;
    localparam int ITD  = 2;
    localparam int AW_A = 9;
    localparam int AW_B = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sample_en = 1'b0;
    logic [7:0]     theta = '0;
    logic [7:0]     distance = '0;
    logic [W-1:0]   signal_in = '0;
    logic [CH*W-1:0] so_a, so_b;
    logic           ov_a, ov_b, busy_a, busy_b, orun_a, orun_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    spatial_delay #(.W(W), .ADDR_W(AW_A), .CH(CH), .ITD_SHIFT(ITD)) dut_a (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .theta(theta),
        .distance(distance), .signal_in(signal_in), .signal_out(so_a),
        .out_valid(ov_a), .busy(busy_a), .overrun(orun_a));

    spatial_delay #(.W(W), .ADDR_W(AW_B), .CH(CH), .ITD_SHIFT(ITD)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .theta(theta),
        .distance(distance), .signal_in(signal_in), .signal_out(so_b),
        .out_valid(ov_b), .busy(busy_b), .overrun(orun_b));

    // Reference model: full sample history, per-channel delay in samples
    int              hist[$];
    int              cur_m[2][CH];
    logic [CH*W-1:0] exp_a[$];
    logic [CH*W-1:0] exp_b[$];

    function automatic int tgt(int lim, int c, int th, int d);
        int diff = (th - c * (256 / CH) + 256) % 256;
        int fold = (diff > 128) ? 256 - diff : diff;
        int t    = d + (fold >> ITD);
        return (t > lim) ? lim : t;
    endfunction

    function automatic void model_accept(int s, int th, int d);
        hist.push_back(s);
        for (int i = 0; i < 2; i++) begin
            int lim = (i == 0) ? (1 << AW_A) - 1 : (1 << AW_B) - 1;
            logic [CH*W-1:0] e = '0;
            for (int c = 0; c < CH; c++) begin
                int t = tgt(lim, c, th, d);
                if (cur_m[i][c] < t) cur_m[i][c]++;
                else if (cur_m[i][c] > t) cur_m[i][c]--;
                if (cur_m[i][c] < hist.size())
                    e[c*W +: W] = W'(hist[hist.size() - 1 - cur_m[i][c]]);
            end
            if (i == 0) exp_a.push_back(e);
            else        exp_b.push_back(e);
        end
    endfunction

    function automatic void model_reset();
        hist.delete();
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < CH; c++)
                cur_m[i][c] = 0;
    endfunction

    task automatic chk(input string nm, input logic [CH*W-1:0] act, input logic [CH*W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", nm, act, req);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov_a) begin
                if (exp_a.size() == 0) chkb("unexpected_valid_a", 1'b1, 1'b0);
                else chk("data_a", so_a, exp_a.pop_front());
            end
            if (ov_b) begin
                if (exp_b.size() == 0) chkb("unexpected_valid_b", 1'b1, 1'b0);
                else chk("data_b", so_b, exp_b.pop_front());
            end
        end
    end

    // Caller must sit on a negedge when gap == 0
    task automatic send(input int gap, input logic [W-1:0] s, input logic [7:0] th, input logic [7:0] d);
        repeat (gap) @(negedge clk);
        sample_en = 1'b1;
        signal_in = s;
        theta     = th;
        distance  = d;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        signal_in = W'($urandom);
        theta     = 8'($urandom);
        distance  = 8'($urandom);
        model_accept(s, th, d);
        for (int k = 1; k <= CH + 3; k++) begin
            @(negedge clk);
            chkb($sformatf("busy_a_c%0d", k), busy_a, k <= CH + 2);
            chkb($sformatf("busy_b_c%0d", k), busy_b, k <= CH + 2);
            chkb($sformatf("valid_a_c%0d", k), ov_a, k == CH + 3);
            chkb($sformatf("valid_b_c%0d", k), ov_b, k == CH + 3);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_out_a"}, so_a, '0);
        chk({tag, "_out_b"}, so_b, '0);
        chkb({tag, "_valid_a"}, ov_a, 1'b0);
        chkb({tag, "_valid_b"}, ov_b, 1'b0);
        chkb({tag, "_busy_a"}, busy_a, 1'b0);
        chkb({tag, "_busy_b"}, busy_b, 1'b0);
        chkb({tag, "_overrun_a"}, orun_a, 1'b0);
        chkb({tag, "_overrun_b"}, orun_b, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset held with strobes toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample_en = (i % 2 == 1);
            signal_in = W'($urandom);
        end
        @(negedge clk);
        sample_en = 1'b0;
        chk_idle_zero("reset");
        rst_n = 1'b1;

        // Impulse, settle, second impulse
        send(1, 16'h1000, 8'd0, 8'd0);
        for (int i = 0; i < 40; i++) send(0, '0, 8'd0, 8'd0);
        send(0, 16'h1000, 8'd0, 8'd0);
        for (int i = 0; i < 40; i++) send(0, '0, 8'd0, 8'd0);

        // Slew toward distance 10
        for (int i = 0; i < 15; i++)
            send($urandom_range(0, 3), W'($urandom), 8'd0, 8'd10);
        chkb("no_overrun_a", orun_a, 1'b0);
        chkb("no_overrun_b", orun_b, 1'b0);

        // Overrun: second strobe in cycle 2 is dropped
        @(negedge clk);
        sample_en = 1'b1; signal_in = 16'h1234; theta = 8'd0; distance = 8'd10;
        @(posedge clk); #1;
        sample_en = 1'b0;
        model_accept(16'h1234, 0, 10);
        @(negedge clk);
        @(negedge clk);
        sample_en = 1'b1; signal_in = 16'hdead; theta = 8'd77; distance = 8'd200;
        @(posedge clk); #1;
        sample_en = 1'b0;
        for (int k = 3; k <= CH + 3; k++) begin
            @(negedge clk);
            chkb($sformatf("ovr_valid_a_c%0d", k), ov_a, k == CH + 3);
        end
        chkb("overrun_set_a", orun_a, 1'b1);
        chkb("overrun_set_b", orun_b, 1'b1);
        for (int i = 0; i < 5; i++)
            send($urandom_range(0, 2), W'($urandom), 8'($urandom), 8'd10);
        chkb("overrun_held_a", orun_a, 1'b1);
        chkb("overrun_held_b", orun_b, 1'b1);

        // Reset pulse clears overrun and all history
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk_idle_zero("reset_pulse");
        rst_n = 1'b1;

        // Fill: early samples read zero until history is deep enough
        for (int i = 0; i < 8; i++) send(1, W'($urandom), 8'd0, 8'd3);

        // Clamp and pointer wrap
        for (int i = 0; i < 100; i++) send(0, W'($urandom), 8'd128, 8'd255);

        // Random angles, distances, gaps
        for (int i = 0; i < 120; i++)
            send($urandom_range(0, 2), W'($urandom), 8'($urandom), 8'($urandom));

        // Reset in the middle of a sequence suppresses out_valid
        @(negedge clk);
        sample_en = 1'b1; signal_in = 16'h5a5a;
        @(posedge clk); #1;
        sample_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chkb("abort_busy_a", busy_a, 1'b0);
        chkb("abort_busy_b", busy_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < CH + 4; k++) begin
            @(negedge clk);
            chkb($sformatf("abort_valid_a_%0d", k), ov_a, 1'b0);
            chkb($sformatf("abort_valid_b_%0d", k), ov_b, 1'b0);
        end
        chk_idle_zero("abort");

        for (int i = 0; i < 6; i++)
            send(1, W'($urandom), 8'($urandom), 8'($urandom_range(0, 6)));

        repeat (CH + 5) @(negedge clk);
        chk("pending_a", CH*W'(exp_a.size()), '0);
        chk("pending_b", CH*W'(exp_b.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
